input_row_fetch_scheduler: RTL and testbench

Sequences DDR3 reads for the convolution input stream. Walks the (row group, input layer) iteration order and issues one AXI4 read burst per 64-byte row. Writes returned beats into a two-bank ping-pong row buffer (block RAM) and hands each filled bank to the 3x3 window streamer with a ready/release handshake.
Sits between the AXI-lite configuration registers, the shared AXI read master and the window streamer.

---
 rtl/input_layer_pkg.sv | 27 ++
 rtl/pingpong_bank_tracker.sv | 58 +++++
 rtl/input_row_fetch_scheduler.sv | 175 +++++++++++++++++
 tb/tb_input_row_fetch_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_layer_pkg.sv
// Shared constants, FSM state encoding and bank descriptor type for the
// input row fetch scheduler.
package input_layer_pkg;

   localparam int BURST_BYTES        = 64;
   localparam int LAYER_STRIDE_SHIFT = 12;
   localparam int ROW_STRIDE_SHIFT   = $clog2(BURST_BYTES);

   localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
   localparam logic [3:0] AXI_CACHE_NORMAL = 4'b0011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_BANK,
      ST_ADDR,
      ST_DATA,
      ST_NEXT,
      ST_DRAIN
   } state_e;

   typedef struct packed {
      logic [9:0] layer;
      logic [9:0] row_base;
      logic [2:0] rows;
   } bank_desc_t;

endpackage

// File: rtl/pingpong_bank_tracker.sv
// Two-bank ping-pong bookkeeping: write/read pointers, filled flags and the
// descriptor captured for each bank when it is handed to the consumer.
module pingpong_bank_tracker
   import input_layer_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       set,
   input  logic [9:0] set_layer,
   input  logic [9:0] set_row_base,
   input  logic [2:0] set_rows,
   input  logic       free,
   output logic       wr_ptr,
   output logic [1:0] bank_rdy,
   output logic [9:0] layer_id,
   output logic [9:0] row_base,
   output logic [2:0] rows
);

   logic       rd_ptr;
   logic       free_ok;
   logic [1:0] rdy_next;
   bank_desc_t desc [2];

   // A release against an empty bank is dropped without moving the read pointer.
   assign free_ok = free && bank_rdy[rd_ptr];

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      rdy_next = bank_rdy;
      if (free_ok) rdy_next[rd_ptr] = 1'b0;
      if (set)     rdy_next[wr_ptr] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         bank_rdy <= 2'b00;
         // NOTE: only two descriptor entries, reset so the outputs read 0 out of reset.
         for (int i = 0; i < 2; i++) desc[i] <= '0;
      end else begin
         bank_rdy <= rdy_next;
         if (free_ok) rd_ptr <= ~rd_ptr;
         if (set) begin
            desc[wr_ptr] <= '{layer: set_layer, row_base: set_row_base, rows: set_rows};
            wr_ptr       <= ~wr_ptr;
         end
      end
   end

   assign layer_id = desc[rd_ptr].layer;
   assign row_base = desc[rd_ptr].row_base;
   assign rows     = desc[rd_ptr].rows;

endmodule

// File: rtl/input_row_fetch_scheduler.sv
// Walks (row group, layer) pairs, issues one AXI read burst per 64-byte row
// and fills a two-bank ping-pong row buffer for the window streamer.
module input_row_fetch_scheduler
   import input_layer_pkg::*;
#(
   parameter int C_S_AXI_ID_WIDTH   = 3,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 64,
   parameter int C_S_AXI_BURST_LEN  = 8,
   parameter int BUF_ROWS           = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] axi_address,
   input  logic [9:0]                    no_of_input_layers,
   input  logic [9:0]                    input_layer_row_size,
   output logic                          busy,
   output logic                          done,
   output logic                          rresp_err,
   output logic [C_S_AXI_ID_WIDTH-1:0]   M_axi_arid,
   output logic [C_S_AXI_ADDR_WIDTH-1:0] M_axi_araddr,
   output logic [7:0]                    M_axi_arlen,
   output logic [2:0]                    M_axi_arsize,
   output logic [1:0]                    M_axi_arburst,
   output logic                          M_axi_arvalid,
   input  logic                          M_axi_arready,
   input  logic [C_S_AXI_ID_WIDTH-1:0]   M_axi_rid,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] M_axi_rdata,
   input  logic [1:0]                    M_axi_rresp,
   input  logic                          M_axi_rlast,
   input  logic                          M_axi_rvalid,
   output logic                          M_axi_rready,
   output logic                          buf_wr_en,
   output logic [5:0]                    buf_wr_addr,
   output logic [C_S_AXI_DATA_WIDTH-1:0] buf_wr_data,
   output logic [1:0]                    bank_rdy,
   output logic [9:0]                    bank_layer_id,
   output logic [9:0]                    bank_row_base,
   output logic [2:0]                    bank_rows,
   input  logic                          bank_release
);

   localparam int         AW        = C_S_AXI_ADDR_WIDTH;
   localparam logic [2:0] BEAT_LAST = 3'(C_S_AXI_BURST_LEN - 1);

   state_e          state, state_next;
   logic [AW-1:0]   cfg_base;
   logic [9:0]      cfg_layers, cfg_rows;
   logic [9:0]      layer, row_base, row, rows_left;
   logic [1:0]      row_off;
   logic [2:0]      beat, rows_cur;
   logic            last_row, last_pair, bank_set, wr_ptr;

   // rid and rlast carry nothing the beat counter does not already know.
   logic unused;
   assign unused = &{1'b0, M_axi_rid, M_axi_rlast};

   assign rows_left = cfg_rows - row_base;
   assign rows_cur  = (rows_left >= 10'(BUF_ROWS)) ? 3'(BUF_ROWS) : rows_left[2:0];
   assign row       = row_base + {8'b0, row_off};
   assign last_row  = ({1'b0, row_off} + 3'd1) == rows_cur;
   assign last_pair = (layer == cfg_layers - 10'd1) && (row_base == cfg_rows - 10'd3);

   assign M_axi_arid    = C_S_AXI_ID_WIDTH'(1);
   assign M_axi_arlen   = 8'(C_S_AXI_BURST_LEN - 1);
   assign M_axi_arsize  = 3'($clog2(C_S_AXI_DATA_WIDTH / 8));
   assign M_axi_arburst = AXI_BURST_INCR;
   assign M_axi_araddr  = cfg_base
                        + (AW'(layer) << LAYER_STRIDE_SHIFT)
                        + (AW'(row) << ROW_STRIDE_SHIFT);

   assign busy        = (state != ST_IDLE);
   assign buf_wr_addr = {wr_ptr, row_off, beat};
   assign buf_wr_data = M_axi_rdata;

   always_comb begin
      state_next    = state;
      M_axi_arvalid = 1'b0;
      M_axi_rready  = 1'b0;
      buf_wr_en     = 1'b0;
      bank_set      = 1'b0;
      done          = 1'b0;
      case (state)
         ST_IDLE:      if (start) state_next = ST_WAIT_BANK;
         ST_WAIT_BANK: if (!bank_rdy[wr_ptr]) state_next = ST_ADDR;
         ST_ADDR: begin
            M_axi_arvalid = 1'b1;
            if (M_axi_arready) state_next = ST_DATA;
         end
         ST_DATA: begin
            M_axi_rready = 1'b1;
            if (M_axi_rvalid) begin
               buf_wr_en = 1'b1;
               if (beat == BEAT_LAST) state_next = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (!last_row) begin
               state_next = ST_ADDR;
            end else begin
               bank_set   = 1'b1;
               state_next = last_pair ? ST_DRAIN : ST_WAIT_BANK;
            end
         end
         ST_DRAIN: begin
            if (bank_rdy == 2'b00) begin
               done       = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cfg_base   <= '0;
         cfg_layers <= '0;
         cfg_rows   <= '0;
         layer      <= '0;
         row_base   <= '0;
         row_off    <= '0;
         beat       <= '0;
         rresp_err  <= 1'b0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && start) begin
            cfg_base   <= axi_address;
            cfg_layers <= no_of_input_layers;
            cfg_rows   <= input_layer_row_size;
            layer      <= '0;
            row_base   <= '0;
            row_off    <= '0;
            beat       <= '0;
            rresp_err  <= 1'b0;
         end
         if (buf_wr_en) begin
            beat <= beat + 3'd1;
            if (M_axi_rresp != 2'b00) rresp_err <= 1'b1;
         end
         // Layer is the inner loop; row_base only moves after the last layer.
         if (state == ST_NEXT) begin
            if (!last_row) begin
               row_off <= row_off + 2'd1;
            end else begin
               row_off <= '0;
               if (layer == cfg_layers - 10'd1) begin
                  layer    <= '0;
                  row_base <= row_base + 10'd1;
               end else begin
                  layer <= layer + 10'd1;
               end
            end
         end
      end
   end

   pingpong_bank_tracker u_tracker (
      .clk          (clk),
      .reset_n      (reset_n),
      .set          (bank_set),
      .set_layer    (layer),
      .set_row_base (row_base),
      .set_rows     (rows_cur),
      .free         (bank_release),
      .wr_ptr       (wr_ptr),
      .bank_rdy     (bank_rdy),
      .layer_id     (bank_layer_id),
      .row_base     (bank_row_base),
      .rows         (bank_rows)
   );

endmodule

// File: tb/tb_input_row_fetch_scheduler.sv
// Bench for input_row_fetch_scheduler: stalling AXI read slave, randomly
// releasing consumer and a loop-nest reference model of bursts and buffer writes.
module tb_input_row_fetch_scheduler;

   logic        clk = 1'b0;
   logic        reset_n, start;
   logic [31:0] axi_address;
   logic [9:0]  no_of_input_layers, input_layer_row_size;
   logic        busy, done, rresp_err;
   logic [2:0]  M_axi_arid;
   logic [31:0] M_axi_araddr;
   logic [7:0]  M_axi_arlen;
   logic [2:0]  M_axi_arsize;
   logic [1:0]  M_axi_arburst;
   logic        M_axi_arvalid, M_axi_arready;
   logic [2:0]  M_axi_rid;
   logic [63:0] M_axi_rdata;
   logic [1:0]  M_axi_rresp;
   logic        M_axi_rlast, M_axi_rvalid, M_axi_rready;
   logic        buf_wr_en;
   logic [5:0]  buf_wr_addr;
   logic [63:0] buf_wr_data;
   logic [1:0]  bank_rdy;
   logic [9:0]  bank_layer_id, bank_row_base;
   logic [2:0]  bank_rows;
   logic        bank_release;

   always #5 clk = ~clk;

   input_row_fetch_scheduler dut (
      .clk(clk), .reset_n(reset_n), .start(start), .axi_address(axi_address),
      .no_of_input_layers(no_of_input_layers), .input_layer_row_size(input_layer_row_size),
      .busy(busy), .done(done), .rresp_err(rresp_err),
      .M_axi_arid(M_axi_arid), .M_axi_araddr(M_axi_araddr), .M_axi_arlen(M_axi_arlen),
      .M_axi_arsize(M_axi_arsize), .M_axi_arburst(M_axi_arburst),
      .M_axi_arvalid(M_axi_arvalid), .M_axi_arready(M_axi_arready),
      .M_axi_rid(M_axi_rid), .M_axi_rdata(M_axi_rdata), .M_axi_rresp(M_axi_rresp),
      .M_axi_rlast(M_axi_rlast), .M_axi_rvalid(M_axi_rvalid), .M_axi_rready(M_axi_rready),
      .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
      .bank_rdy(bank_rdy), .bank_layer_id(bank_layer_id), .bank_row_base(bank_row_base),
      .bank_rows(bank_rows), .bank_release(bank_release)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Knobs set by the directed sequence, consumed by the slave/consumer process.
   int rel_mode  = 0;   // 0 never release, 1 release at once, 2 random delay
   int max_stall = 0;
   int err_beat  = -1;

   // Observations and bookkeeping written by the slave/monitor process.
   logic [31:0] obs_addr[$];
   logic [5:0]  obs_wa[$];
   logic [63:0] obs_wd[$];
   logic [22:0] obs_desc[$];
   int   cyc = 0, rel_cycle = 0, done_cycle = 0, done_cnt = 0;
   int   ar_unstable = 0, overlap = 0, wr_en_bad = 0, beat_global = 0;
   logic [15:0] ar_const;
   logic        err_after_start, busy_after_start;

   // Reference model output.
   logic [31:0] exp_addr[$];
   logic [5:0]  exp_wa[$];
   logic [63:0] exp_wd[$];
   logic [22:0] exp_desc[$];
   logic        model_wr_ptr = 1'b0;

   function automatic logic [63:0] ddr_word(input logic [31:0] a, input int b);
      logic [31:0] ba;
      ba = a + 32'(b) * 32'd8;
      return {ba, ba ^ 32'hA5C3_0F1E};
   endfunction

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Slave, consumer and monitor: inputs driven 1 after negedge, outputs sampled 2 after.
   initial begin
      logic        s_busy, ar_hs, r_hs, c_ptr, prev_arvalid, prev_ar_hs;
      logic [31:0] s_addr, prev_araddr;
      int          s_beat, ar_stall, r_stall, rel_wait;
      s_busy = 0; ar_hs = 0; r_hs = 0; c_ptr = 0; prev_arvalid = 0; prev_ar_hs = 0;
      s_addr = 0; prev_araddr = 0; s_beat = 0; ar_stall = 0; r_stall = 0; rel_wait = 0;
      M_axi_arready = 0; M_axi_rvalid = 0; M_axi_rdata = '0; M_axi_rresp = 0;
      M_axi_rlast = 0; M_axi_rid = 0; bank_release = 0;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (!reset_n) begin
            s_busy = 0; ar_hs = 0; r_hs = 0; c_ptr = 0; ar_stall = 0; r_stall = 0; rel_wait = 0;
            M_axi_arready = 0; M_axi_rvalid = 0; M_axi_rdata = '0; M_axi_rresp = 0;
            M_axi_rlast = 0; bank_release = 0;
         end else begin
            if (ar_hs) begin
               s_busy = 1; s_beat = 0;
               ar_stall = $urandom_range(0, max_stall);
               r_stall  = $urandom_range(0, max_stall);
            end
            if (r_hs) begin
               s_beat++; beat_global++;
               r_stall = $urandom_range(0, max_stall);
               if (s_beat == 8) s_busy = 0;
            end
            if (!s_busy) begin
               M_axi_rvalid = 0; M_axi_rlast = 0; M_axi_rresp = 0;
               if (ar_stall > 0) begin M_axi_arready = 0; ar_stall--; end
               else M_axi_arready = 1;
            end else begin
               M_axi_arready = 0;
               if (r_stall > 0) begin
                  M_axi_rvalid = 0; r_stall--;
               end else begin
                  M_axi_rvalid = 1;
                  M_axi_rdata  = ddr_word(s_addr, s_beat);
                  M_axi_rresp  = (beat_global == err_beat) ? 2'd2 : 2'd0;
                  M_axi_rlast  = (s_beat == 7);
                  M_axi_rid    = 3'($urandom);
               end
            end
            bank_release = 0;
            if (rel_mode != 0 && bank_rdy[c_ptr]) begin
               if (rel_wait > 0) rel_wait--;
               else begin
                  bank_release = 1;
                  obs_desc.push_back({bank_layer_id, bank_row_base, bank_rows});
                  c_ptr = ~c_ptr;
                  rel_cycle = cyc;
                  rel_wait = (rel_mode == 2) ? $urandom_range(0, 6) : 0;
               end
            end
         end
         #1;
         ar_hs = M_axi_arvalid && M_axi_arready;
         r_hs  = M_axi_rvalid && M_axi_rready;
         if (ar_hs) begin
            s_addr   = M_axi_araddr;
            ar_const = {M_axi_arid, M_axi_arlen, M_axi_arsize, M_axi_arburst};
            obs_addr.push_back(M_axi_araddr);
         end
         if (buf_wr_en !== r_hs) wr_en_bad++;
         if (buf_wr_en) begin
            obs_wa.push_back(buf_wr_addr);
            obs_wd.push_back(buf_wr_data);
         end
         if (reset_n && prev_arvalid && !prev_ar_hs &&
             (!M_axi_arvalid || M_axi_araddr !== prev_araddr)) ar_unstable++;
         if (M_axi_arvalid && M_axi_rready) overlap++;
         if (done) begin done_cnt++; done_cycle = cyc; end
         prev_arvalid = M_axi_arvalid;
         prev_ar_hs   = ar_hs;
         prev_araddr  = M_axi_araddr;
      end
   end

   // Loop-nest model: row groups outer, layers inner, one bank per pair.
   task automatic build_model(input int n, input int r, input logic [31:0] base);
      logic bank;
      exp_addr.delete(); exp_wa.delete(); exp_wd.delete(); exp_desc.delete();
      bank = model_wr_ptr;
      for (int rb = 0; rb <= r - 3; rb++) begin
         for (int l = 0; l < n; l++) begin
            int rows;
            rows = (r - rb < 4) ? r - rb : 4;
            exp_desc.push_back({10'(l), 10'(rb), 3'(rows)});
            for (int k = 0; k < rows; k++) begin
               logic [31:0] a;
               a = base + 32'(l) * 32'd4096 + 32'(rb + k) * 32'd64;
               exp_addr.push_back(a);
               for (int b = 0; b < 8; b++) begin
                  exp_wa.push_back({bank, 2'(k), 3'(b)});
                  exp_wd.push_back(ddr_word(a, b));
               end
            end
            bank = ~bank;
         end
      end
      model_wr_ptr = bank;
   endtask

   task automatic run_start(input int n, input int r, input logic [31:0] base);
      @(negedge clk);
      build_model(n, r, base);
      obs_addr.delete(); obs_wa.delete(); obs_wd.delete(); obs_desc.delete();
      done_cnt = 0; ar_unstable = 0; overlap = 0; wr_en_bad = 0; beat_global = 0;
      axi_address = base;
      no_of_input_layers = 10'(n);
      input_layer_row_size = 10'(r);
      start = 1;
      @(negedge clk);
      start = 0;
      #2;
      err_after_start  = rresp_err;
      busy_after_start = busy;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      #3;
      check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
   endtask

   task automatic check_run(input string tag, input int n_addr, input bit full);
      check({tag, " burst count"}, 64'(obs_addr.size()), 64'(n_addr));
      for (int i = 0; i < n_addr && i < obs_addr.size(); i++) begin
         check($sformatf("%s araddr[%0d]", tag, i), 64'(obs_addr[i]), 64'(exp_addr[i]));
         if (obs_addr[i] !== exp_addr[i]) break;
      end
      check({tag, " write count"}, 64'(obs_wa.size()), 64'(8 * n_addr));
      for (int i = 0; i < 8 * n_addr && i < obs_wa.size(); i++) begin
         check($sformatf("%s wr_addr[%0d]", tag, i), 64'(obs_wa[i]), 64'(exp_wa[i]));
         check($sformatf("%s wr_data[%0d]", tag, i), obs_wd[i], exp_wd[i]);
         if (obs_wa[i] !== exp_wa[i] || obs_wd[i] !== exp_wd[i]) break;
      end
      check({tag, " araddr stable"}, 64'(ar_unstable), 64'd0);
      check({tag, " one outstanding"}, 64'(overlap), 64'd0);
      check({tag, " wr_en vs beats"}, 64'(wr_en_bad), 64'd0);
      check({tag, " ar constants"}, 64'(ar_const), 64'({3'd1, 8'd7, 3'd3, 2'd1}));
      if (full) begin
         check({tag, " released banks"}, 64'(obs_desc.size()), 64'(exp_desc.size()));
         for (int i = 0; i < exp_desc.size() && i < obs_desc.size(); i++)
            check($sformatf("%s desc[%0d]", tag, i), 64'(obs_desc[i]), 64'(exp_desc[i]));
         check({tag, " busy after done"}, 64'(busy), 64'd0);
         check({tag, " bank_rdy after done"}, 64'(bank_rdy), 64'd0);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " arvalid"}, 64'(M_axi_arvalid), 64'd0);
      check({tag, " rready"}, 64'(M_axi_rready), 64'd0);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " done"}, 64'(done), 64'd0);
      check({tag, " rresp_err"}, 64'(rresp_err), 64'd0);
      check({tag, " buf_wr_en"}, 64'(buf_wr_en), 64'd0);
      check({tag, " bank_rdy"}, 64'(bank_rdy), 64'd0);
      check({tag, " araddr"}, 64'(M_axi_araddr), 64'd0);
      check({tag, " buf_wr_addr"}, 64'(buf_wr_addr), 64'd0);
      check({tag, " bank desc"}, 64'({bank_layer_id, bank_row_base, bank_rows}), 64'd0);
   endtask

   initial begin
      int          n;
      logic [31:0] base;
      reset_n = 0; start = 0; axi_address = 0;
      no_of_input_layers = 0; input_layer_row_size = 0;
      repeat (3) @(negedge clk);
      #2;
      check_zero("reset");
      @(negedge clk);
      reset_n = 1;

      // Single bank, zero-latency slave, immediate release.
      rel_mode = 1; max_stall = 0; err_beat = -1;
      run_start(1, 3, 32'h1000_0000);
      check("t1 busy after start", 64'(busy_after_start), 64'd1);
      wait_done("t1", 2000);
      check_run("t1", 3, 1'b1);
      check("t1 done after release", 64'(done_cycle), 64'(rel_cycle + 1));

      // No consumer: both banks fill, then the scheduler parks in WAIT_BANK.
      rel_mode = 0;
      run_start(2, 4, 32'h2000_0000);
      repeat (300) @(negedge clk);
      #3;
      check_run("t2", 8, 1'b0);
      check("t2 bank_rdy", 64'(bank_rdy), 64'd3);
      check("t2 arvalid idle", 64'(M_axi_arvalid), 64'd0);
      check("t2 busy", 64'(busy), 64'd1);
      check("t2 head layer", 64'(bank_layer_id), 64'd0);
      check("t2 head rows", 64'(bank_rows), 64'd4);
      repeat (50) @(negedge clk);
      #3;
      check("t2 no further bursts", 64'(obs_addr.size()), 64'd8);
      @(negedge clk); reset_n = 0;
      @(negedge clk); reset_n = 1;
      model_wr_ptr = 1'b0;

      // Partial last group: rows 4,4,3 across banks 0,1,0.
      rel_mode = 2; max_stall = 0;
      run_start(1, 5, 32'h3000_0000);
      wait_done("t3", 4000);
      check_run("t3", 11, 1'b1);

      // Random shapes with AR/R stalls of 0..5 cycles.
      rel_mode = 2; max_stall = 5;
      for (int t = 0; t < 4; t++) begin
         base = $urandom;
         base = base & 32'hFFFF_F000;
         run_start($urandom_range(1, 3), $urandom_range(3, 7), base);
         wait_done($sformatf("t4.%0d", t), 20000);
         check_run($sformatf("t4.%0d", t), exp_addr.size(), 1'b1);
      end

      // Error response on one beat: sticky until the next start.
      max_stall = 2; err_beat = 13;
      run_start(1, 3, 32'h4000_0000);
      wait_done("t5a", 4000);
      check_run("t5a", 3, 1'b1);
      check("t5a rresp_err sticky", 64'(rresp_err), 64'd1);
      err_beat = -1;
      run_start(2, 3, 32'h4100_0000);
      check("t5b err cleared by start", 64'(err_after_start), 64'd0);
      wait_done("t5b", 6000);
      check_run("t5b", 6, 1'b1);
      check("t5b rresp_err", 64'(rresp_err), 64'd0);

      // Reset in the middle of a burst, then a clean rerun from row 0.
      max_stall = 3;
      run_start(1, 5, 32'h5000_0000);
      n = 0;
      while (obs_wa.size() < 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t6 reached beat 3", 64'(obs_wa.size() >= 3), 64'd1);
      reset_n = 0;
      @(negedge clk);
      #2;
      check_zero("t6 after reset");
      @(negedge clk);
      reset_n = 1;
      model_wr_ptr = 1'b0;
      run_start(1, 5, 32'h5000_0000);
      wait_done("t6 rerun", 10000);
      check_run("t6 rerun", 11, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
